// File: rtl/game_tick_pkg.sv
// Shared state encoding, default rates and helpers for the game tick engine.
package game_tick_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_STEP  = 2'd2
    } tick_state_e;

    localparam int CLK_HZ_DEF       = 50_000_000;
    localparam int DEFAULT_HZ_DEF   = 60;
    localparam int DEBOUNCE_CYC_DEF = 500_000;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_tick_engine_if.sv
// Divisor configuration bus: one-cycle write of cfg_div into channel cfg_ch.
interface game_tick_engine_if
    import game_tick_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 32
);
    localparam int CH_W = ch_w(NUM_CH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_we, cfg_ch, cfg_div);
    modport slave  (input  cfg_we, cfg_ch, cfg_div);
endinterface

// File: rtl/game_tick_engine_step_conditioner.sv
// Step-button conditioner: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Debounce is built only when TICK_DEBOUNCE_EN is defined.
module step_conditioner
    import game_tick_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic step_pulse_o
);
    logic s1_q, s2_q, prev_q;
    logic clean;

    if (DEBOUNCE_CYC < 1) begin : g_cfg_err
        $error("step_conditioner: DEBOUNCE_CYC must be at least 1");
    end

`ifdef TICK_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    logic [DB_W-1:0] db_cnt_q;
    logic            db_q;

    // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (s2_q == db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            db_q     <= s2_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end
    assign clean = db_q;
`else
    assign clean = s2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            prev_q <= clean;
        end
    end

    assign step_pulse_o = clean & ~prev_q;
endmodule

// File: rtl/game_tick_engine.sv
// Multi-channel programmable tick generator with RUN / PAUSE / STEP modes.
// Define TICK_DEBOUNCE_EN to debounce step_btn inside step_conditioner.
module game_tick_engine
    import game_tick_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEF,
    parameter int NUM_CH       = 2,
    parameter int DIV_W        = 32,
    parameter int DEFAULT_HZ   = DEFAULT_HZ_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              mode_sw,
    input  logic              pause,
    input  logic              step_btn,
    game_tick_engine_if.slave cfg,
    output logic [NUM_CH-1:0] tick,
    output logic              pix_en,
    output logic [15:0]       frame_cnt,
    output logic [1:0]        state
);
    localparam int CH_W      = ch_w(NUM_CH);
    localparam int DIV_RST_I = (CLK_HZ / DEFAULT_HZ > 0) ? (CLK_HZ / DEFAULT_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_I);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    tick_state_e state_q, state_d;
    logic        mode_s1_q, mode_s2_q;
    logic        step_pulse;

    logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [NUM_CH-1:0]            tick_q, tick_d, wr_sel, term;
    logic                         pix_q;
    logic [15:0]                  frame_q;

    step_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (
        .clk          (clk_50mhz),
        .rst_n        (rst_n),
        .btn_i        (step_btn),
        .step_pulse_o (step_pulse)
    );

    // Mode for this cycle drives the datapath directly; state_q is its registered view.
    always_comb begin
        state_d = ST_RUN;
        if (pause)          state_d = ST_PAUSE;
        else if (mode_s2_q) state_d = ST_STEP;
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
            term[i]   = (cnt_q[i] == div_q[i] - ONE);
        end
    end

    // STEP holds counters at zero, so leaving STEP (directly or via PAUSE) restarts from 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]  = div_q[i];
            cnt_d[i]  = cnt_q[i];
            tick_d[i] = 1'b0;
            unique case (state_d)
                ST_RUN: begin
                    cnt_d[i]  = term[i] ? '0 : cnt_q[i] + ONE;
                    tick_d[i] = term[i] && !wr_sel[i];
                end
                ST_STEP: begin
                    cnt_d[i]  = '0;
                    tick_d[i] = step_pulse;
                end
                default: ;
            endcase
            if (wr_sel[i]) begin
                div_d[i] = (cfg.cfg_div == '0) ? ONE : cfg.cfg_div;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            div_q     <= {NUM_CH{DIV_RST}};
            cnt_q     <= '0;
            tick_q    <= '0;
            pix_q     <= 1'b0;
            frame_q   <= '0;
        end else begin
            mode_s1_q <= mode_sw;
            mode_s2_q <= mode_s1_q;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            pix_q     <= ~pix_q;
            if (tick_q[0]) frame_q <= frame_q + 16'd1;
        end
    end

    assign tick      = tick_q;
    assign pix_en    = pix_q;
    assign frame_cnt = frame_q;
    assign state     = state_q;
endmodule

// File: tb/tb_game_tick_engine.sv
// Scoreboard bench for game_tick_engine: expected ticks queued per scenario, checked at negedge.
module tb_game_tick_engine;
    import game_tick_pkg::*;

    localparam int NUM_CH       = 3;
    localparam int DIV_W        = 32;
    localparam int CLK_HZ       = 1200;
    localparam int DEFAULT_HZ   = 60;
    localparam int DEBOUNCE_CYC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_sw = 1'b0, pause = 1'b0, step_btn = 1'b0;
    logic [NUM_CH-1:0] tick;
    logic              pix_en;
    logic [15:0]       frame_cnt;
    logic [1:0]        state;

    game_tick_engine_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_bus ();

    game_tick_engine #(
        .CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .DIV_W(DIV_W),
        .DEFAULT_HZ(DEFAULT_HZ), .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .mode_sw   (mode_sw),
        .pause     (pause),
        .step_btn  (step_btn),
        .cfg       (cfg_bus),
        .tick      (tick),
        .pix_en    (pix_en),
        .frame_cnt (frame_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    // Cycle n = the interval following the n-th rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_tick: no tick at cycle %0d, required mask %b",
                         exp_q[0].cyc, exp_q[0].mask);
                void'(exp_q.pop_front());
            end
            if (tick !== '0) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    if (tick !== exp_q[0].mask) begin
                        errors++;
                        $display("FAIL tick_mask: cycle %0d got %b, required %b",
                                 cyc, tick, exp_q[0].mask);
                    end
                    void'(exp_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_tick: cycle %0d got %b, required 000", cyc, tick);
                end
            end
        end
    end

    task automatic expect_tick(input int c, input logic [NUM_CH-1:0] m);
        exp_t e;
        e.cyc  = c;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mode_sw = 1'b0; pause = 1'b0; step_btn = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_div = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive a write now so the next rising edge samples it.
    task automatic cfg_write(input int ch, input int dv);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = 2'(ch);
        cfg_bus.cfg_div = DIV_W'(dv);
        to_cyc(cyc + 1);
        cfg_bus.cfg_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_div = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tick !== '0)       begin errors++; $display("FAIL reset_tick: got %b, required 000", tick); end
        checks++; if (pix_en !== 1'b0)   begin errors++; $display("FAIL reset_pix: got %b, required 0", pix_en); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame: got %0d, required 0", frame_cnt); end
        checks++; if (state !== ST_RUN)  begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
        rst_n = 1'b1;
        to_cyc(1);
        checks++; if (pix_en !== 1'b1)   begin errors++; $display("FAIL pix_c1: got %b, required 1", pix_en); end
        to_cyc(2);
        checks++; if (pix_en !== 1'b0)   begin errors++; $display("FAIL pix_c2: got %b, required 0", pix_en); end
    endtask

    task automatic test_run();
        apply_reset();
        expect_tick(20, 3'b111);
        expect_tick(40, 3'b111);
        expect_tick(60, 3'b111);
        to_cyc(60);
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL run_frame60: got %0d, required 2", frame_cnt); end
        to_cyc(61);
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL run_frame61: got %0d, required 3", frame_cnt); end
        checks++; if (state !== ST_RUN)    begin errors++; $display("FAIL run_state: got %0d, required 0", state); end
        to_cyc(62);
        checks++; if (exp_q.size() !== 0)  begin errors++; $display("FAIL run_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_cfg();
        apply_reset();
        expect_tick(12, 3'b010);
        expect_tick(17, 3'b010);
        expect_tick(20, 3'b101);
        expect_tick(22, 3'b010);
        for (int c = 26; c <= 45; c++) expect_tick(c, (c == 40) ? 3'b110 : 3'b010);
        to_cyc(6);  cfg_write(1, 5);
        to_cyc(24); cfg_write(1, 0);
        to_cyc(29); cfg_write(3, 7);
        to_cyc(39); cfg_write(0, 20);
        to_cyc(46);
        checks++; if (exp_q.size() !== 0)  begin errors++; $display("FAIL cfg_pending: %0d ticks outstanding, required 0", exp_q.size()); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL cfg_frame: got %0d, required 1", frame_cnt); end
    endtask

    task automatic test_pause();
        apply_reset();
        expect_tick(70, 3'b111);
        expect_tick(90, 3'b111);
        to_cyc(10); pause = 1'b1;
        to_cyc(25); mode_sw = 1'b1;
        to_cyc(30);
        checks++; if (state !== ST_PAUSE)  begin errors++; $display("FAIL pause_state: got %0d, required 1", state); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL pause_frame: got %0d, required 0", frame_cnt); end
        step_btn = 1'b1;
        to_cyc(35); step_btn = 1'b0;
        to_cyc(40); mode_sw = 1'b0;
        to_cyc(60); pause = 1'b0;
        to_cyc(62);
        checks++; if (state !== ST_RUN)    begin errors++; $display("FAIL unpause_state: got %0d, required 0", state); end
        to_cyc(91);
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL pause_frame91: got %0d, required 2", frame_cnt); end
        checks++; if (exp_q.size() !== 0)  begin errors++; $display("FAIL pause_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_step();
        int nstep;
        apply_reset();
        mode_sw = 1'b1;
`ifdef TICK_DEBOUNCE_EN
        expect_tick(23, 3'b111);
        nstep = 1;
`else
        expect_tick(13, 3'b111);
        expect_tick(19, 3'b111);
        nstep = 2;
`endif
        expect_tick(52, 3'b111);
        to_cyc(10); step_btn = 1'b1;
        to_cyc(12); step_btn = 1'b0;
        to_cyc(16); step_btn = 1'b1;
        to_cyc(20);
        checks++; if (state !== ST_STEP) begin errors++; $display("FAIL step_state: got %0d, required 2", state); end
        to_cyc(26); step_btn = 1'b0;
        to_cyc(30); mode_sw = 1'b0;
        to_cyc(53);
        checks++; if (frame_cnt !== 16'(nstep + 1)) begin errors++; $display("FAIL step_frame: got %0d, required %0d", frame_cnt, nstep + 1); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL step_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        expect_tick(20, 3'b111);
        to_cyc(33); step_btn = 1'b1;
        to_cyc(34); pause = 1'b1;
        to_cyc(35);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL pre_reset_frame: got %0d, required 1", frame_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (tick !== '0)         begin errors++; $display("FAIL mid_reset_tick: got %b, required 000", tick); end
        checks++; if (pix_en !== 1'b0)     begin errors++; $display("FAIL mid_reset_pix: got %b, required 0", pix_en); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_frame: got %0d, required 0", frame_cnt); end
        checks++; if (state !== ST_RUN)    begin errors++; $display("FAIL mid_reset_state: got %0d, required 0", state); end
        step_btn = 1'b0; pause = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_tick(20, 3'b111);
        to_cyc(21);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL restart_frame: got %0d, required 1", frame_cnt); end
        checks++; if (exp_q.size() !== 0)  begin errors++; $display("FAIL restart_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_cfg();
        test_pause();
        test_step();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
